mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//   Round-robin arbiter for one shared resource reached through a 4-to-1 MUX
//   (e.g. the single memory port used by IF, MEM, DMA and debug paths).
//   - Grants one requester at a time.
//   - Drives the registered 2-bit select that feeds the 4-to-1 MUX.
//   - Holds the grant until the resource signals done.
//   - Aborts a stuck transaction after a programmable timeout.
// PARAMETERS
//   TIMEOUT  16  max BUSY cycles without done before forced release; 0 = disabled
//   CNT_W    5   timeout counter width; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//   clk          in   1  clock, rising edge
//   rst_n        in   1  synchronous reset, active low
//   req          in   4  request, one bit per requester, level-held
//   done         in   1  resource completion, 1-cycle pulse, valid only in BUSY
//   grant        out  4  one-hot grant (registered); 4'b0000 when idle
//   sel          out  2  MUX select = index of granted requester (registered)
//   busy         out  1  1 while a grant is outstanding
//   timeout_err  out  1  1-cycle pulse: grant was released by timeout
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge)
//     - grant=0, sel=0, busy=0, timeout_err=0, cnt=0, state=IDLE, last=3.
//     - Applies mid-transaction too: an outstanding grant is dropped with no done.
//   States: IDLE, BUSY.
//   Arbitration
//     - Search order starts at last+1 and wraps modulo 4.
//       With last=3 the order is 0,1,2,3.
//     - Winner w = first asserted req bit in that order.
//     - The previous winner therefore has lowest priority.
//   IDLE
//     - If req!=0: on the next edge grant=1<<w, sel=w, last=w, busy=1, cnt=0,
//       state -> BUSY.
//     - Latency: req rising to grant visible is 1 cycle.
//   BUSY, done=1
//     - Transaction ends at the next edge.
//     - If any req is asserted in the done cycle (including the current
//       owner's), re-arbitrate on that same edge. This gives a back-to-back
//       grant with no idle gap: grant, sel and last update, cnt=0, stay BUSY.
//     - Otherwise grant=0, busy=0, state -> IDLE. sel holds its last value.
//   BUSY, done=0
//     - cnt increments.
//     - If TIMEOUT!=0 and cnt==TIMEOUT-1: next edge grant=0, busy=0,
//       timeout_err=1 for one cycle, state -> IDLE.
//       No back-to-back grant on a timeout.
//     - Timeout release occurs after exactly TIMEOUT BUSY cycles.
//   done and timeout in the same cycle: done wins; no error is flagged.
//   Owner drops req while BUSY: grant is held anyway; only done or timeout
//   releases it.
//   done while IDLE: ignored, no state change.
//   Invariants
//     - grant is always zero or one-hot.
//     - When busy=1, grant[sel]==1.
//     - busy == (grant != 0).
// TESTING
//   1. Reset: hold rst_n=0 with req=4'hF
//      -> grant=0, busy=0, sel=0, timeout_err=0 on every cycle.
//   2. Single request: req=4'b0100 from IDLE
//      -> next cycle grant=4'b0100, sel=2, busy=1.
//      done pulse -> following cycle grant=0, busy=0.
//   3. Fairness: req=4'hF held, done pulsed every 3rd cycle
//      -> grant order 0,1,2,3,0, each back-to-back with no idle cycle.
//   4. Timeout (TIMEOUT=16): grant req[1], never pulse done
//      -> 16 BUSY cycles, then grant=0 and a single-cycle timeout_err=1.
//      The next grant goes to req[2] if it is asserted.
//   5. Collision: done and timeout in the same cycle
//      -> no timeout_err; normal release or re-grant.
//   6. Mid-op reset: rst_n=0 while grant=4'b1000
//      -> next cycle grant=0, busy=0.
//      After release, req=4'hF -> grant=4'b0001 (last reset to 3).

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between the requesters, the shared resource and the
// round-robin arbiter that steers the 4-to-1 MUX.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       timeout_err;

  modport master (
    output req,
    output done,
    input  grant,
    input  sel,
    input  busy,
    input  timeout_err
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output sel,
    output busy,
    output timeout_err
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for one shared resource behind a 4-to-1 MUX: holds a
// grant until done, aborts a stuck owner after TIMEOUT busy cycles.
module mux4_rr_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  mux4_rr_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam bit               TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_r, state_nxt_s;
  logic [3:0]       grant_r, grant_nxt_s;
  logic [1:0]       sel_r, sel_nxt_s;
  logic [1:0]       last_r, last_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             terr_r, terr_nxt_s;
  logic [2:0]       pick_s;
  logic             win_s;
  logic [1:0]       win_idx_s;
  logic             to_hit_s;

  // Returns {found, index}; search starts at last+1 so the previous winner ranks last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      res = r[idx] ? {1'b1, idx} : res;
    end
    return res;
  endfunction

  assign pick_s    = rr_pick(bus.req, last_r);
  assign win_s     = pick_s[2];
  assign win_idx_s = pick_s[1:0];
  assign to_hit_s  = TO_EN && (cnt_r == TO_LAST);

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      grant_r <= 4'b0000;
      sel_r   <= 2'd0;
      last_r  <= 2'd3;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      terr_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      grant_r <= grant_nxt_s;
      sel_r   <= sel_nxt_s;
      last_r  <= last_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= busy_nxt_s;
      terr_r  <= terr_nxt_s;
    end
  end

  // Next-state decision.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (win_s) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (bus.done) begin
          state_nxt_s = win_s ? ST_BUSY : ST_IDLE;
        end else if (to_hit_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs; done beats a same-cycle timeout.
  always_comb begin
    grant_nxt_s = grant_r;
    sel_nxt_s   = sel_r;
    last_nxt_s  = last_r;
    cnt_nxt_s   = cnt_r;
    busy_nxt_s  = busy_r;
    terr_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = {CNT_W{1'b0}};
        if (win_s) begin
          grant_nxt_s = 4'b0001 << win_idx_s;
          sel_nxt_s   = win_idx_s;
          last_nxt_s  = win_idx_s;
          busy_nxt_s  = 1'b1;
        end else begin
          grant_nxt_s = 4'b0000;
          busy_nxt_s  = 1'b0;
        end
      end
      ST_BUSY: begin
        if (bus.done) begin
          cnt_nxt_s = {CNT_W{1'b0}};
          if (win_s) begin
            grant_nxt_s = 4'b0001 << win_idx_s;
            sel_nxt_s   = win_idx_s;
            last_nxt_s  = win_idx_s;
            busy_nxt_s  = 1'b1;
          end else begin
            grant_nxt_s = 4'b0000;
            busy_nxt_s  = 1'b0;
          end
        end else if (to_hit_s) begin
          cnt_nxt_s   = {CNT_W{1'b0}};
          grant_nxt_s = 4'b0000;
          busy_nxt_s  = 1'b0;
          terr_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        grant_nxt_s = 4'b0000;
        busy_nxt_s  = 1'b0;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  assign bus.grant       = grant_r;
  assign bus.sel         = sel_r;
  assign bus.busy        = busy_r;
  assign bus.timeout_err = terr_r;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed-vector bench: the stimulus pushes the hand-computed post-edge
// outputs into a scoreboard queue; a monitor pops and compares every cycle.
module tb_mux4_rr_arbiter;

  typedef struct {
    string      name;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       terr;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   n_pushed;
  bit   stim_done;
  exp_t exp_q[$];

  mux4_rr_arbiter_if ifc();

  mux4_rr_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector for n cycles; the expected outputs after each edge are queued.
  task automatic vec(input string name, input logic rst, input logic [3:0] req,
                     input logic dn, input logic [3:0] eg, input logic [1:0] es,
                     input logic eb, input logic et, input int n = 1);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst_n    = rst;
      ifc.req  = req;
      ifc.done = dn;
      e.name  = name;
      e.grant = eg;
      e.sel   = es;
      e.busy  = eb;
      e.terr  = et;
      exp_q.push_back(e);
      n_pushed++;
    end
  endtask

  // Monitor: one comparison per cycle, just after the active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (ifc.grant === e.grant && ifc.sel === e.sel &&
            ifc.busy === e.busy && ifc.timeout_err === e.terr) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got grant=%b sel=%0d busy=%b terr=%b, want grant=%b sel=%0d busy=%b terr=%b",
                   e.name, ifc.grant, ifc.sel, ifc.busy, ifc.timeout_err,
                   e.grant, e.sel, e.busy, e.terr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_pass = 0; n_pushed = 0; stim_done = 1'b0;
    rst_n = 1'b0; ifc.req = 4'h0; ifc.done = 1'b0;

    // Reset held with all requests asserted
    vec("reset_hold", 1'b0, 4'hF, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 3);

    // Single request, then release on done
    vec("single_grant",   1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    vec("single_release", 1'b1, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
    vec("done_idle",      1'b1, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);

    // Fairness from last=3: order 0,1,2,3,0 back-to-back
    vec("fair_reset", 1'b0, 4'h0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    vec("fair_g0",    1'b1, 4'hF, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 2);
    vec("fair_g1",    1'b1, 4'hF, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);
    vec("fair_h1",    1'b1, 4'hF, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 2);
    vec("fair_g2",    1'b1, 4'hF, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0);
    vec("fair_h2",    1'b1, 4'hF, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 2);
    vec("fair_g3",    1'b1, 4'hF, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0);
    vec("fair_h3",    1'b1, 4'hF, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 2);
    vec("fair_g0b",   1'b1, 4'hF, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0);
    vec("fair_rel",   1'b1, 4'h0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Timeout: req[1] wins from last=0, held 16 cycles, then pulse and regrant to req[2]
    vec("to_grant", 1'b1, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    vec("to_hold",  1'b1, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 15);
    vec("to_fire",  1'b1, 4'b0110, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b1);
    vec("to_next",  1'b1, 4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);

    // Collision: done on the final timeout cycle re-grants with no error
    vec("col_hold",  1'b1, 4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 15);
    vec("col_done",  1'b1, 4'b0110, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);
    vec("col_rel",   1'b1, 4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);

    // Owner drops req while busy: grant held
    vec("drop_grant", 1'b1, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    vec("drop_hold",  1'b1, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 2);

    // Mid-transaction reset, then last restarts at 3
    vec("midrst",     1'b0, 4'hF, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 2);
    vec("post_rst",   1'b1, 4'hF, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    vec("post_rel",   1'b1, 4'h0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);

    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    stim_done = 1'b1;

    n_checks++;
    if (exp_q.size() == 0 && n_checks == n_pushed + 1) begin
      n_pass++;
    end else begin
      $display("FAIL scoreboard_drain: got %0d left, %0d compared, want 0 left, %0d compared",
               exp_q.size(), n_checks - 1, n_pushed);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
